// File: rtl/prog_mealy_machine_if.sv
// ---------------------------------------------------------------------------
// prog_mealy_machine_if
// Bundles the configuration bus, the symbol stream and the status outputs of
// prog_mealy_machine.
//   cfg_we / cfg_addr / cfg_data : table write port, entry = {next_state, out}
//   in_valid / in                : input symbol stream
//   out / out_valid              : Mealy output, combinational
//   state / step_cnt / err       : current state, saturating step count,
//                                  sticky error flag
// master: the side that programs the table and feeds symbols.
// slave : the machine itself.
// ---------------------------------------------------------------------------
interface prog_mealy_machine_if #(
  parameter int STATE_W = 3,
  parameter int IN_W    = 1,
  parameter int OUT_W   = 1,
  parameter int CNT_W   = 16
);
  logic                     cfg_we;
  logic [STATE_W+IN_W-1:0]  cfg_addr;
  logic [STATE_W+OUT_W-1:0] cfg_data;
  logic                     in_valid;
  logic [IN_W-1:0]          in;
  logic [OUT_W-1:0]         out;
  logic                     out_valid;
  logic [STATE_W-1:0]       state;
  logic [CNT_W-1:0]         step_cnt;
  logic                     err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in,
    input  out, out_valid, state, step_cnt, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in,
    output out, out_valid, state, step_cnt, err
  );
endinterface

// File: rtl/prog_mealy_machine.sv
// ---------------------------------------------------------------------------
// prog_mealy_machine
// Table-driven Mealy machine. A table of 2^(STATE_W+IN_W) entries, indexed by
// {state, symbol}, holds {next_state, out}. Each cycle with in_valid high the
// machine emits the entry's out and loads its next_state on the clock edge.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset; clears state, counter, error flag
//          and every table entry to {RESET_STATE, 0}
//   bus  : prog_mealy_machine_if.slave (config port, symbol stream, status)
// ---------------------------------------------------------------------------
module prog_mealy_machine #(
  parameter int STATE_W     = 3,
  parameter int NUM_STATES  = 6,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 1,
  parameter int RESET_STATE = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  prog_mealy_machine_if.slave   bus
);

  localparam int ADDR_W = STATE_W + IN_W;
  localparam int DATA_W = STATE_W + OUT_W;
  localparam int DEPTH  = 1 << ADDR_W;

  // One extra bit so NUM_STATES == 2^STATE_W is representable.
  localparam logic [STATE_W:0]     NUM_STATES_L = (STATE_W+1)'(NUM_STATES);
  localparam logic [STATE_W-1:0]   RST_ST       = STATE_W'(RESET_STATE);
  localparam logic [DATA_W-1:0]    RST_ENTRY    = {RST_ST, {OUT_W{1'b0}}};
  localparam logic [CNT_W-1:0]     CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1);

  // Table lives in registers: it must be cleared in one cycle on reset and
  // read combinationally for the Mealy output.
  logic [DATA_W-1:0]  r_table [DEPTH];
  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_step_cnt;
  logic               r_err;

  logic [ADDR_W-1:0]  w_idx;
  logic [DATA_W-1:0]  w_entry;
  logic               w_state_ok;
  logic               w_step;
  logic               w_bad_step;
  logic               w_wr_legal;
  logic               w_wr_ok;
  logic               w_wr_bad;

  assign w_idx      = {r_state, bus.in};
  // Read happens before this cycle's write lands, so a same-index write and
  // step naturally see the old entry.
  assign w_entry    = r_table[w_idx];
  assign w_state_ok = ({1'b0, r_state} < NUM_STATES_L);
  assign w_step     = bus.in_valid && w_state_ok;
  assign w_bad_step = bus.in_valid && !w_state_ok;

  assign w_wr_legal = ({1'b0, bus.cfg_data[DATA_W-1:OUT_W]} < NUM_STATES_L);
  assign w_wr_ok    = bus.cfg_we && w_wr_legal;
  assign w_wr_bad   = bus.cfg_we && !w_wr_legal;

  // Output is forced low during reset and whenever no legal step is taken.
  assign bus.out       = (w_step && !rst) ? w_entry[OUT_W-1:0] : '0;
  assign bus.out_valid = bus.in_valid;
  assign bus.state     = r_state;
  assign bus.step_cnt  = r_step_cnt;
  assign bus.err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= RST_ENTRY;
      end
    end else if (w_wr_ok) begin
      r_table[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RST_ST;
      r_step_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_bad_step) begin
        r_state <= RST_ST;
      end else if (w_step) begin
        r_state <= w_entry[DATA_W-1:OUT_W];
      end
      if (w_step && (r_step_cnt != CNT_MAX)) begin
        r_step_cnt <= r_step_cnt + CNT_ONE;
      end
      if (w_bad_step || w_wr_bad) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
